// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared ISA-subset constants, class decoders and hazard-tracking types
// for the stall controller and the operand-forwarding unit.
package hazard_stall_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_kind_t;

    typedef struct packed {
        logic [4:0] dest;
        logic [1:0] tnew;
        md_kind_t   md_kind;
    } entry_t;

    function automatic logic is_special(input logic [5:0] fn);
        return fn inside {FN_JR, FN_JALR, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    endfunction

    function automatic logic is_cal_i(input logic [5:0] op);
        return op inside {OP_LUI, OP_ORI, OP_ANDI, OP_XORI, OP_ADDI, OP_ADDIU,
                          OP_SLTI, OP_SLTIU};
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SW, OP_SH, OP_SB};
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ};
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Classifies one instruction into its hazard profile: destination,
// Tnew at E entry, Tuse per source and mult/div involvement.
module hazard_decode
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  dest,
    output logic [1:0]  tnew,
    output logic [1:0]  tuse_rs,
    output logic [1:0]  tuse_rt,
    output md_kind_t    md_kind,
    output logic        is_md_user
);
    logic [5:0] op, fn;
    logic       rtype, cal_r, cal_i, load, store, branch, beq_bne;
    logic       jal, jr, jalr, mult, div, mf, mt;

    assign op      = ir[31:26];
    assign fn      = ir[5:0];
    assign rtype   = (op == OP_RTYPE);
    assign cal_r   = rtype && (ir != 32'd0) && !is_special(fn);
    assign cal_i   = is_cal_i(op);
    assign load    = is_load(op);
    assign store   = is_store(op);
    assign branch  = is_branch(op);
    assign beq_bne = (op == OP_BEQ) || (op == OP_BNE);
    assign jal     = (op == OP_JAL);
    assign jr      = rtype && (fn == FN_JR);
    assign jalr    = rtype && (fn == FN_JALR);
    assign mult    = rtype && (fn inside {FN_MULT, FN_MULTU});
    assign div     = rtype && (fn inside {FN_DIV, FN_DIVU});
    assign mf      = rtype && (fn inside {FN_MFHI, FN_MFLO});
    assign mt      = rtype && (fn inside {FN_MTHI, FN_MTLO});

    always_comb begin
        dest = 5'd0;
        if (jal)                    dest = 5'd31;
        else if (cal_r || jalr || mf) dest = ir[15:11];
        else if (cal_i || load)     dest = ir[20:16];

        tnew = 2'd0;
        if (load)                   tnew = TNEW_LOAD;
        else if (cal_r || cal_i)    tnew = TNEW_ALU;

        tuse_rs = TUSE_NONE;
        if (branch || jr || jalr)   tuse_rs = TUSE_0;
        else if (cal_r || cal_i || load || store || mult || div || mt)
                                    tuse_rs = TUSE_1;

        tuse_rt = TUSE_NONE;
        if (beq_bne)                tuse_rt = TUSE_0;
        else if (cal_r || mult || div) tuse_rt = TUSE_1;
        else if (store)             tuse_rt = TUSE_2;

        md_kind = MD_NONE;
        if (mult)                   md_kind = MD_MULT;
        else if (div)               md_kind = MD_DIV;
    end

    assign is_md_user = mult || div || mf || mt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall controller: shadows E/M/W destination/Tnew, compares against D-stage
// Tuse, and runs the mult/div busy counter that holds back HI/LO users.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    output logic        stall,
    output logic        pc_en,
    output logic        ir_d_en,
    output logic        e_clr,
    output logic        md_busy,
    output logic        md_start
);
    localparam int CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    entry_t           e_q, m_q, w_q, d_entry;
    logic [CNT_W-1:0] md_cnt;
    logic [1:0]       tuse_rs, tuse_rt;
    logic             is_md_user, stall_rs, stall_rt, md_stall;
    logic [4:0]       rs, rt;

    hazard_decode u_dec (
        .ir         (IR_D),
        .dest       (d_entry.dest),
        .tnew       (d_entry.tnew),
        .tuse_rs    (tuse_rs),
        .tuse_rt    (tuse_rt),
        .md_kind    (d_entry.md_kind),
        .is_md_user (is_md_user)
    );

    function automatic logic hazard(input entry_t en, input logic [4:0] r,
                                    input logic [1:0] tuse);
        return (r != 5'd0) && (en.dest == r) && (tuse < en.tnew);
    endfunction

    function automatic entry_t age(input entry_t en);
        entry_t a;
        a = en;
        if (a.tnew != 2'd0) a.tnew = a.tnew - 2'd1;
        return a;
    endfunction

    assign rs       = IR_D[25:21];
    assign rt       = IR_D[20:16];
    assign stall_rs = hazard(e_q, rs, tuse_rs) || hazard(m_q, rs, tuse_rs);
    assign stall_rt = hazard(e_q, rt, tuse_rt) || hazard(m_q, rt, tuse_rt);
    assign md_busy  = (md_cnt != '0);
    assign md_start = (e_q.md_kind != MD_NONE);
    assign md_stall = is_md_user && (md_busy || md_start);
    assign stall    = stall_rs || stall_rt || md_stall;
    assign pc_en    = !stall;
    assign ir_d_en  = !stall;
    assign e_clr    = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            md_cnt <= '0;
        end else begin
            e_q <= stall ? '0 : d_entry;
            m_q <= age(e_q);
            w_q <= age(m_q);
            // The counter starts as the md op leaves E, so busy covers the
            // cycles after md_start.
            case (e_q.md_kind)
                MD_MULT: md_cnt <= CNT_W'(MULT_CYCLES);
                MD_DIV:  md_cnt <= CNT_W'(DIV_CYCLES);
                default: if (md_cnt != '0) md_cnt <= md_cnt - 1'b1;
            endcase
        end
    end

    // W is kept for lockstep with the pipeline but its Tnew is always 0.
    logic unused_w;
    assign unused_w = ^w_q;

endmodule
